multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 67 ++++++
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control_alu_op_decoder.sv | 57 +++++
 rtl/multicycle_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM states, ALU operation codes, opcodes and datapath select values.
`timescale 1ns/1ps
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC_R  = 4'd6,
        EXEC_I  = 4'd7,
        ALU_WB  = 4'd8,
        BRANCH  = 4'd9,
        JAL     = 4'd10,
        ERROR   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_AND   = 4'b0100,
        ALU_I_SLL = 4'b0101,
        ALU_I_SRL = 4'b0110,
        ALU_R_SLL = 4'b0111,
        ALU_R_SRL = 4'b1000,
        ALU_SLT   = 4'b1001,
        ALU_MUL   = 4'b1010,
        ALU_NONE  = 4'b1111
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_MEM_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    // beq takes on zero, bne on !zero; other branch flavours never load the PC.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit (master) and the datapath/memory side (slave).
`timescale 1ns/1ps
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_operation;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_operation, illegal, state
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_operation, illegal, state
    );

endinterface

// File: rtl/multicycle_control_alu_op_decoder.sv
// Combinational map from opcode/funct3/funct7 to ALU operation and legality.
`timescale 1ns/1ps
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_operation,
    output logic       legal
);

    always_comb begin
        alu_operation = ALU_ADD;
        legal         = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == 7'b0000001) begin
                    if (funct3 == 3'b000) alu_operation = ALU_MUL;
                    else                  legal = 1'b0;
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) alu_operation = ALU_SUB;
                    else                  legal = 1'b0;
                end else if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: alu_operation = ALU_ADD;
                        3'b001: alu_operation = ALU_R_SLL;
                        3'b010: alu_operation = ALU_SLT;
                        3'b011: legal = 1'b0;
                        3'b100: alu_operation = ALU_XOR;
                        3'b101: alu_operation = ALU_R_SRL;
                        3'b110: alu_operation = ALU_OR;
                        3'b111: alu_operation = ALU_AND;
                    endcase
                end else begin
                    legal = 1'b0;
                end
            end
            OP_ITYPE: begin
                case (funct3)
                    3'b000: alu_operation = ALU_ADD;
                    3'b001: alu_operation = ALU_I_SLL;
                    3'b010: alu_operation = ALU_SLT;
                    3'b011: legal = 1'b0;
                    3'b100: alu_operation = ALU_XOR;
                    3'b101: alu_operation = ALU_I_SRL;
                    3'b110: alu_operation = ALU_OR;
                    3'b111: alu_operation = ALU_AND;
                endcase
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (!legal) alu_operation = ALU_NONE;
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle RV32 subset; outputs decode from the
// current state, with mem_ready/zero/funct3 feeding the enables where needed.
`timescale 1ns/1ps
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t     state_q;
    logic       illegal_q;
    alu_op_t    dec_op;
    logic       dec_legal;

    logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c, adr_src_c;
    logic [1:0] src_a_c, src_b_c, result_src_c;
    alu_op_t    op_c;

    alu_op_decoder u_alu_op_decoder (
        .opcode        (bus.opcode),
        .funct3        (bus.funct3),
        .funct7        (bus.funct7),
        .alu_operation (dec_op),
        .legal         (dec_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH:   if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    if (!dec_legal) begin
                        state_q   <= ERROR;
                        illegal_q <= 1'b1;
                    end else begin
                        case (bus.opcode)
                            OP_LOAD, OP_STORE: state_q <= MEM_ADR;
                            OP_RTYPE:          state_q <= EXEC_R;
                            OP_ITYPE:          state_q <= EXEC_I;
                            OP_BRANCH:         state_q <= BRANCH;
                            OP_JAL:            state_q <= JAL;
                            default: begin
                                state_q   <= ERROR;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                end
                MEM_ADR: state_q <= (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                MEM_RD:  if (bus.mem_ready) state_q <= MEM_WB;
                MEM_WB:  state_q <= FETCH;
                MEM_WR:  if (bus.mem_ready) state_q <= FETCH;
                EXEC_R:  state_q <= ALU_WB;
                EXEC_I:  state_q <= ALU_WB;
                ALU_WB:  state_q <= FETCH;
                BRANCH:  state_q <= FETCH;
                JAL:     state_q <= ALU_WB;
                ERROR:   state_q <= ERROR;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = ADR_PC;
        src_a_c      = SRC_A_PC;
        src_b_c      = SRC_B_RS2;
        result_src_c = RES_ALU_OUT;
        op_c         = ALU_NONE;
        case (state_q)
            FETCH: begin
                src_b_c      = SRC_B_FOUR;
                result_src_c = RES_ALU_RESULT;
                op_c         = ALU_ADD;
                pc_write_c   = bus.mem_ready;
                ir_write_c   = bus.mem_ready;
            end
            DECODE: begin
                src_a_c = SRC_A_OLD_PC;
                src_b_c = SRC_B_IMM;
                op_c    = ALU_ADD;
            end
            MEM_ADR: begin
                src_a_c = SRC_A_RS1;
                src_b_c = SRC_B_IMM;
                op_c    = ALU_ADD;
            end
            MEM_RD: adr_src_c = ADR_RESULT;
            MEM_WB: begin
                result_src_c = RES_MEM_DATA;
                reg_write_c  = 1'b1;
            end
            MEM_WR: begin
                adr_src_c   = ADR_RESULT;
                mem_write_c = 1'b1;
            end
            EXEC_R: begin
                src_a_c = SRC_A_RS1;
                op_c    = dec_op;
            end
            EXEC_I: begin
                src_a_c = SRC_A_RS1;
                src_b_c = SRC_B_IMM;
                op_c    = dec_op;
            end
            ALU_WB: reg_write_c = 1'b1;
            BRANCH: begin
                src_a_c    = SRC_A_RS1;
                op_c       = ALU_SUB;
                pc_write_c = branch_taken(bus.funct3, bus.zero);
            end
            JAL: begin
                src_a_c    = SRC_A_OLD_PC;
                src_b_c    = SRC_B_FOUR;
                op_c       = ALU_ADD;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset directly so an abort takes effect without waiting for a clock.
    assign bus.pc_write      = pc_write_c  & reset;
    assign bus.ir_write      = ir_write_c  & reset;
    assign bus.reg_write     = reg_write_c & reset;
    assign bus.mem_write     = mem_write_c & reset;
    assign bus.adr_src       = adr_src_c;
    assign bus.alu_src_a     = src_a_c;
    assign bus.alu_src_b     = src_b_c;
    assign bus.result_src    = result_src_c;
    assign bus.alu_operation = op_c;
    assign bus.illegal       = illegal_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized and directed bench for multicycle_control against an instruction-level trace model.
`timescale 1ns/1ps
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] a, b, rs;
        logic [3:0] op;
        logic       ill;
    } obs_t;

    typedef struct {
        logic  mr;
        logic  z;
        obs_t  e;
        string tag;
    } step_t;

    step_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic obs_t base(input state_t s);
        obs_t o;
        o = '0;
        o.st = s;
        o.op = 4'hF;
        return o;
    endfunction

    function automatic obs_t fetch_obs(input logic mr);
        obs_t o;
        o = base(FETCH);
        o.b = 2'b10;
        o.rs = 2'b10;
        o.op = 4'h0;
        o.pcw = mr;
        o.irw = mr;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st  = bus.state;
        o.pcw = bus.pc_write;
        o.irw = bus.ir_write;
        o.rw  = bus.reg_write;
        o.mw  = bus.mem_write;
        o.adr = bus.adr_src;
        o.a   = bus.alu_src_a;
        o.b   = bus.alu_src_b;
        o.rs  = bus.result_src;
        o.op  = bus.alu_operation;
        o.ill = bus.illegal;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected ALU op for R/I instructions, returned as {legal, op}.
    function automatic logic [4:0] ref_op(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] tr [8];
        logic [3:0] ti [8];
        tr = '{4'h0, 4'h7, 4'h9, 4'hF, 4'h2, 4'h8, 4'h3, 4'h4};
        ti = '{4'h0, 4'h5, 4'h9, 4'hF, 4'h2, 4'h6, 4'h3, 4'h4};
        if (!is_r)                     return {f3 != 3'd3, ti[f3]};
        if (f7 == 7'h00)               return {f3 != 3'd3, tr[f3]};
        if (f7 == 7'h01 && f3 == 3'd0) return {1'b1, 4'hA};
        if (f7 == 7'h20 && f3 == 3'd0) return {1'b1, 4'h1};
        return {1'b0, 4'hF};
    endfunction

    task automatic push(input logic mr, input logic z, input obs_t e, input string tag);
        step_t s;
        s.mr = mr; s.z = z; s.e = e; s.tag = tag;
        q.push_back(s);
    endtask

    task automatic build_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic zb, input int fw, input int mw, input string tag,
                               output logic err);
        obs_t e;
        logic [4:0] lo;
        err = 1'b0;
        for (int i = 0; i < fw; i++) push(1'b0, rb(), fetch_obs(1'b0), {tag, "/fetch_wait"});
        push(1'b1, rb(), fetch_obs(1'b1), {tag, "/fetch"});
        e = base(DECODE); e.a = 2'b01; e.b = 2'b01; e.op = 4'h0;
        push(rb(), rb(), e, {tag, "/decode"});
        case (opc)
            7'b0000011, 7'b0100011: begin
                e = base(MEM_ADR); e.a = 2'b10; e.b = 2'b01; e.op = 4'h0;
                push(rb(), rb(), e, {tag, "/mem_adr"});
                e = base(opc == 7'b0000011 ? MEM_RD : MEM_WR);
                e.adr = 1'b1;
                e.mw = (opc == 7'b0100011);
                for (int i = 0; i < mw; i++) push(1'b0, rb(), e, {tag, "/mem_wait"});
                push(1'b1, rb(), e, {tag, "/mem_done"});
                if (opc == 7'b0000011) begin
                    e = base(MEM_WB); e.rs = 2'b01; e.rw = 1'b1;
                    push(rb(), rb(), e, {tag, "/mem_wb"});
                end
            end
            7'b0110011, 7'b0010011: begin
                lo = ref_op(opc == 7'b0110011, f3, f7);
                if (lo[4]) begin
                    e = base(opc == 7'b0110011 ? EXEC_R : EXEC_I);
                    e.a = 2'b10; e.b = (opc == 7'b0110011) ? 2'b00 : 2'b01; e.op = lo[3:0];
                    push(rb(), rb(), e, {tag, "/exec"});
                    e = base(ALU_WB); e.rw = 1'b1;
                    push(rb(), rb(), e, {tag, "/alu_wb"});
                end else begin
                    err = 1'b1;
                end
            end
            7'b1100011: begin
                e = base(BRANCH); e.a = 2'b10; e.op = 4'h1;
                e.pcw = (f3 == 3'd0) ? zb : ((f3 == 3'd1) ? !zb : 1'b0);
                push(rb(), zb, e, {tag, "/branch"});
            end
            7'b1101111: begin
                e = base(JAL); e.pcw = 1'b1; e.a = 2'b01; e.b = 2'b10; e.op = 4'h0;
                push(rb(), rb(), e, {tag, "/jal"});
                e = base(ALU_WB); e.rw = 1'b1;
                push(rb(), rb(), e, {tag, "/alu_wb"});
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            e = base(ERROR); e.ill = 1'b1;
            for (int i = 0; i < 3; i++) push(rb(), rb(), e, {tag, "/error"});
        end
    endtask

    task automatic run_q();
        step_t s;
        obs_t got;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.mem_ready = s.mr;
            bus.zero = s.z;
            @(negedge clk);
            got = sample();
            vectors++;
            if (got !== s.e) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", s.tag, got, s.e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input string tag);
        obs_t got;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        got = sample();
        vectors++;
        if (got !== fetch_obs(1'b0)) begin
            miscompares++;
            $display("FAIL %s/in_reset: got %h, expected %h", tag, got, fetch_obs(1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic zb, input int fw, input int mw, input string tag);
        logic err;
        bus.opcode = opc;
        bus.funct3 = f3;
        bus.funct7 = f7;
        build_instr(opc, f3, f7, zb, fw, mw, tag, err);
        run_q();
        if (err) apply_reset({tag, "/recover"});
    endtask

    task automatic test_reset();
        obs_t got;
        bus.opcode = 7'b0110011; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;
        #3;
        got = sample();
        vectors++;
        if (got !== fetch_obs(1'b0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected %h", got, fetch_obs(1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] ir;
        ir = 32'h002081B3;
        do_instr(ir[6:0], ir[14:12], ir[31:25], 1'b0, 0, 0, "add");
    endtask

    task automatic test_lw_wait();
        do_instr(7'b0000011, 3'd2, 7'd0, 1'b0, 1, 2, "lw_wait");
    endtask

    task automatic test_branch();
        do_instr(7'b1100011, 3'd0, 7'd0, 1'b1, 0, 0, "beq_taken");
        do_instr(7'b1100011, 3'd1, 7'd0, 1'b1, 0, 0, "bne_not_taken");
        do_instr(7'b1100011, 3'd0, 7'd0, 1'b0, 0, 0, "beq_not_taken");
        do_instr(7'b1100011, 3'd1, 7'd0, 1'b0, 0, 0, "bne_taken");
        do_instr(7'b1100011, 3'd4, 7'd0, 1'b1, 0, 0, "blt_never");
    endtask

    task automatic test_mul_illegal();
        do_instr(7'b0110011, 3'd0, 7'b0000001, 1'b0, 0, 0, "mul");
        do_instr(7'b0110011, 3'd7, 7'b0100000, 1'b0, 0, 0, "r_illegal");
        do_instr(7'b0010011, 3'd3, 7'd0, 1'b0, 0, 0, "i_illegal");
    endtask

    task automatic test_sw();
        do_instr(7'b0100011, 3'd2, 7'd0, 1'b0, 0, 3, "sw_wait");
    endtask

    task automatic test_sw_reset();
        logic err;
        obs_t got;
        bus.opcode = 7'b0100011; bus.funct3 = 3'd2; bus.funct7 = 7'd0;
        build_instr(7'b0100011, 3'd2, 7'd0, 1'b0, 0, 3, "sw_abort", err);
        while (q.size() > 4) void'(q.pop_back());
        run_q();
        bus.mem_ready = 1'b0;
        #2;
        vectors++;
        if (bus.mem_write !== 1'b1 || bus.state !== 4'(MEM_WR)) begin
            miscompares++;
            $display("FAIL sw_abort/second_cycle: got state %0d mem_write %b, expected state %0d mem_write 1",
                     bus.state, bus.mem_write, MEM_WR);
        end
        reset = 1'b0;
        #1;
        got = sample();
        vectors++;
        if (got !== fetch_obs(1'b0)) begin
            miscompares++;
            $display("FAIL sw_abort/immediate: got %h, expected %h", got, fetch_obs(1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_instr(7'b0010011, 3'd6, 7'd0, 1'b0, 0, 0, "after_abort");
    endtask

    task automatic test_jal();
        do_instr(7'b1101111, 3'd0, 7'd0, 1'b0, 2, 0, "jal");
    endtask

    task automatic test_random();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: opc = ops[$urandom_range(0, 5)];
                6:       opc = 7'($urandom_range(0, 127));
                default: opc = 7'b0110011;
            endcase
            case ($urandom_range(0, 4))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                3:       f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            do_instr(opc, f3, f7, rb(), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_mul_illegal();
        test_sw();
        test_sw_reset();
        test_jal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
